// File: rtl/tpu_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tpu_dma_pkg
// Brief    : Shared types and AXI constants for the write-back DMA engine.
// Revision : 1.0
// ============================================================================
package tpu_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_BURST   = 3'd3,
        ST_RESP    = 3'd4,
        ST_DONE    = 3'd5
    } dma_state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [2:0] SIZE_4B    = 3'b010;

    localparam int DEFAULT_ARRAY_WIDTH = 16;
    localparam int BEAT_CNT_W          = $clog2(DEFAULT_ARRAY_WIDTH);

endpackage
`default_nettype wire

// File: rtl/row_serializer.sv
`default_nettype none
// ============================================================================
// Module   : row_serializer
// Brief    : Loads one buffer row in parallel and emits it word by word.
// Revision : 1.0
// ============================================================================
module row_serializer
    import tpu_dma_pkg::*;
#(
    parameter int WORDS = DEFAULT_ARRAY_WIDTH,
    parameter int DW    = 32,
    parameter int CNT_W = BEAT_CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] row_in [WORDS],
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic          last
);

    logic [DW-1:0]    r_row [WORDS];
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WORDS; i++) begin
                r_row[i] <= '0;
            end
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_row   <= row_in;
            r_cnt   <= '0;
            r_valid <= 1'b1;
        end else if (r_valid && ready) begin
            if (r_cnt == CNT_W'(WORDS - 1)) begin
                r_valid <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Payload is taken straight from registers, so it is stable while stalled.
    assign valid = r_valid;
    assign data  = r_row[r_cnt];
    assign last  = r_valid && (r_cnt == CNT_W'(WORDS - 1));

endmodule
`default_nettype wire

// File: rtl/axi_writeback_dma.sv
`default_nettype none
// ============================================================================
// Module   : axi_writeback_dma
// Brief    : Streams output-buffer rows to memory, one 16-beat INCR burst per row.
// Revision : 1.0
// ============================================================================
module axi_writeback_dma
    import tpu_dma_pkg::*;
#(
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int DATA_WIDTH_ACCUM     = 32,
    parameter int ADDR_WIDTH           = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_pulse,
    input  logic [31:0]                   dest_addr,
    input  logic [ADDR_WIDTH-1:0]         src_addr,
    input  logic [15:0]                   length,
    output logic                          done_irq,
    output logic                          busy,
    output logic                          error,
    output logic [ADDR_WIDTH-1:0]         buf_rd_addr,
    output logic                          buf_rd_en,
    input  logic [DATA_WIDTH_ACCUM-1:0]   buf_rd_data [SYSTOLIC_ARRAY_WIDTH],
    output logic [31:0]                   m_axi_awaddr,
    output logic [7:0]                    m_axi_awlen,
    output logic [2:0]                    m_axi_awsize,
    output logic [1:0]                    m_axi_awburst,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [DATA_WIDTH_ACCUM-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH_ACCUM/8-1:0] m_axi_wstrb,
    output logic                          m_axi_wlast,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready
);

    localparam logic [31:0] ROW_BYTES  = 32'(SYSTOLIC_ARRAY_WIDTH * (DATA_WIDTH_ACCUM / 8));
    localparam logic [31:0] ALIGN_MASK = 32'h0000_003F;

    dma_state_t            r_state;
    logic [31:0]           r_dest;
    logic [ADDR_WIDTH-1:0] r_row_addr;
    logic [15:0]           r_remaining;
    logic [31:0]           r_awaddr;
    logic [7:0]            r_awlen;
    logic [2:0]            r_awsize;
    logic [1:0]            r_awburst;
    logic                  r_awvalid;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic                  r_bready;
    logic                  r_rd_en;
    logic                  r_done;
    logic                  r_busy;
    logic                  r_error;

    logic w_load;
    logic w_ser_valid;
    logic w_ser_last;
    logic w_aw_hs;
    logic w_w_last_hs;

    assign w_load      = (r_state == ST_RD_WAIT);
    assign w_aw_hs     = r_awvalid && m_axi_awready;
    assign w_w_last_hs = w_ser_valid && w_ser_last && m_axi_wready;

    row_serializer #(
        .WORDS (SYSTOLIC_ARRAY_WIDTH),
        .DW    (DATA_WIDTH_ACCUM),
        .CNT_W ($clog2(SYSTOLIC_ARRAY_WIDTH))
    ) u_row_serializer (
        .clk    (clk),
        .rst    (rst),
        .load   (w_load),
        .row_in (buf_rd_data),
        .ready  (m_axi_wready),
        .valid  (w_ser_valid),
        .data   (m_axi_wdata),
        .last   (w_ser_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_dest      <= '0;
            r_row_addr  <= '0;
            r_remaining <= '0;
            r_awaddr    <= '0;
            r_awlen     <= '0;
            r_awsize    <= '0;
            r_awburst   <= '0;
            r_awvalid   <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_bready    <= 1'b0;
            r_rd_en     <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_pulse) begin
                        r_dest      <= dest_addr & ~ALIGN_MASK;
                        r_row_addr  <= src_addr;
                        r_remaining <= length;
                        r_error     <= 1'b0;
                        r_busy      <= 1'b1;
                        if (length == 16'd0) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_rd_en <= 1'b1;
                            r_state <= ST_RD_REQ;
                        end
                    end
                end
                ST_RD_REQ: begin
                    r_rd_en <= 1'b0;
                    r_state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    // Row lands in the serializer this cycle; AW goes out alongside beat 0.
                    r_awaddr  <= r_dest;
                    r_awlen   <= 8'(SYSTOLIC_ARRAY_WIDTH - 1);
                    r_awsize  <= SIZE_4B;
                    r_awburst <= BURST_INCR;
                    r_awvalid <= 1'b1;
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                    r_state   <= ST_BURST;
                end
                ST_BURST: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_last_hs) begin
                        r_w_done <= 1'b1;
                    end
                    if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_last_hs)) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (r_bready && m_axi_bvalid) begin
                        r_bready    <= 1'b0;
                        if (m_axi_bresp != RESP_OKAY) begin
                            r_error <= 1'b1;
                        end
                        r_row_addr  <= r_row_addr + ADDR_WIDTH'(1);
                        r_dest      <= r_dest + ROW_BYTES;
                        r_remaining <= r_remaining - 16'd1;
                        if (r_remaining == 16'd1) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_rd_en <= 1'b1;
                            r_state <= ST_RD_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign done_irq      = r_done;
    assign busy          = r_busy;
    assign error         = r_error;
    assign buf_rd_addr   = r_row_addr;
    assign buf_rd_en     = r_rd_en;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awlen   = r_awlen;
    assign m_axi_awsize  = r_awsize;
    assign m_axi_awburst = r_awburst;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wvalid  = w_ser_valid;
    assign m_axi_wlast   = w_ser_last;
    assign m_axi_wstrb   = {(DATA_WIDTH_ACCUM/8){w_ser_valid}};
    assign m_axi_bready  = r_bready;

endmodule
`default_nettype wire

// File: tb/tb_axi_writeback_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_writeback_dma
// Brief    : Scoreboard bench for the write-back DMA with a simple AXI slave model.
// Revision : 1.0
// ============================================================================
module tb_axi_writeback_dma;

    localparam int SAW = 16;
    localparam int DW  = 32;
    localparam int AW  = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_pulse = 1'b0;
    logic [31:0]   dest_addr = '0;
    logic [AW-1:0] src_addr = '0;
    logic [15:0]   length = '0;
    logic          done_irq, busy, error;
    logic [AW-1:0] buf_rd_addr;
    logic          buf_rd_en;
    logic [DW-1:0] buf_rd_data [SAW];
    logic [31:0]   m_axi_awaddr;
    logic [7:0]    m_axi_awlen;
    logic [2:0]    m_axi_awsize;
    logic [1:0]    m_axi_awburst;
    logic          m_axi_awvalid;
    logic          m_axi_awready = 1'b1;
    logic [DW-1:0] m_axi_wdata;
    logic [3:0]    m_axi_wstrb;
    logic          m_axi_wlast, m_axi_wvalid;
    logic          m_axi_wready = 1'b1;
    logic [1:0]    m_axi_bresp = 2'b00;
    logic          m_axi_bvalid = 1'b0;
    logic          m_axi_bready;

    axi_writeback_dma #(
        .SYSTOLIC_ARRAY_WIDTH (SAW),
        .DATA_WIDTH_ACCUM     (DW),
        .ADDR_WIDTH           (AW)
    ) dut (
        .clk (clk), .rst (rst), .start_pulse (start_pulse), .dest_addr (dest_addr),
        .src_addr (src_addr), .length (length), .done_irq (done_irq), .busy (busy),
        .error (error), .buf_rd_addr (buf_rd_addr), .buf_rd_en (buf_rd_en),
        .buf_rd_data (buf_rd_data), .m_axi_awaddr (m_axi_awaddr), .m_axi_awlen (m_axi_awlen),
        .m_axi_awsize (m_axi_awsize), .m_axi_awburst (m_axi_awburst),
        .m_axi_awvalid (m_axi_awvalid), .m_axi_awready (m_axi_awready),
        .m_axi_wdata (m_axi_wdata), .m_axi_wstrb (m_axi_wstrb), .m_axi_wlast (m_axi_wlast),
        .m_axi_wvalid (m_axi_wvalid), .m_axi_wready (m_axi_wready),
        .m_axi_bresp (m_axi_bresp), .m_axi_bvalid (m_axi_bvalid), .m_axi_bready (m_axi_bready)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cnt = 0, rd_cnt = 0, awv_cnt = 0, wv_cnt = 0;
    int          done_rel = -1, rd_rel = -1, aw_rel = -1, wlast_rel = -1;
    int          w_beat = 0;
    int          b_owed = 0, b_idx = 0, err_idx = -1;
    bit          stall_en = 1'b0;
    bit          saw_wlast = 1'b0, saw_b = 1'b0;
    logic [31:0] seed = '0;

    logic [AW-1:0] exp_rows [$];
    logic [31:0]   exp_aw   [$];
    logic [31:0]   exp_w    [$];

    function automatic logic [31:0] mem_word(input logic [AW-1:0] row, input int w);
        return seed + 32'(row) * 32'd16 + 32'(w);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Output-buffer model: one-cycle read latency.
    always @(posedge clk) begin
        if (buf_rd_en) begin
            for (int w = 0; w < SAW; w++) buf_rd_data[w] <= mem_word(buf_rd_addr, w);
        end
    end

    // Monitor: samples mid-cycle and checks every handshake against the scoreboard.
    always @(negedge clk) begin
        logic [AW-1:0] er;
        logic [31:0]   ev;
        saw_wlast = 1'b0;
        saw_b     = 1'b0;
        if (!rst) begin
            w_beat = 0;
        end else begin
            if (done_irq) begin done_cnt++; done_rel = cyc - start_cyc; end
            if (m_axi_awvalid) awv_cnt++;
            if (m_axi_wvalid) wv_cnt++;
            if (buf_rd_en) begin
                rd_cnt++; rd_rel = cyc - start_cyc; n_cmp++;
                if (exp_rows.size() == 0) begin
                    n_bad++; $display("FAIL rd_row: unexpected read of row %0d", buf_rd_addr);
                end else begin
                    er = exp_rows.pop_front();
                    if (buf_rd_addr !== er) begin
                        n_bad++; $display("FAIL rd_row: got %0d expected %0d", buf_rd_addr, er);
                    end
                end
            end
            if (m_axi_awvalid && m_axi_awready) begin
                aw_rel = cyc - start_cyc; n_cmp++;
                if (exp_aw.size() == 0) begin
                    n_bad++; $display("FAIL aw: unexpected AW addr %h", m_axi_awaddr);
                end else begin
                    ev = exp_aw.pop_front();
                    if (m_axi_awaddr !== ev || m_axi_awlen !== 8'd15 || m_axi_awsize !== 3'b010 || m_axi_awburst !== 2'b01) begin
                        n_bad++;
                        $display("FAIL aw: got addr=%h len=%0d size=%0d burst=%0d expected addr=%h len=15 size=2 burst=1",
                                 m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, ev);
                    end
                end
            end
            if (m_axi_wvalid && m_axi_wready) begin
                n_cmp++;
                if (exp_w.size() == 0) begin
                    n_bad++; $display("FAIL w: unexpected beat data %h", m_axi_wdata);
                end else begin
                    ev = exp_w.pop_front();
                    if (m_axi_wdata !== ev || m_axi_wlast !== (w_beat == SAW - 1) || m_axi_wstrb !== 4'hF) begin
                        n_bad++;
                        $display("FAIL w beat %0d: got data=%h last=%b strb=%h expected data=%h last=%b strb=f",
                                 w_beat, m_axi_wdata, m_axi_wlast, m_axi_wstrb, ev, (w_beat == SAW - 1));
                    end
                end
                if (m_axi_wlast) wlast_rel = cyc - start_cyc;
                saw_wlast = m_axi_wlast;
                w_beat = (w_beat == SAW - 1) ? 0 : w_beat + 1;
            end
            if (m_axi_bvalid && m_axi_bready) saw_b = 1'b1;
        end
    end

    // Interconnect model: ready stalls and one B response per completed burst.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                m_axi_bvalid = 1'b0;
                b_owed       = 0;
            end else begin
                m_axi_awready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
                m_axi_wready  = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (m_axi_bvalid && saw_b) m_axi_bvalid = 1'b0;
                if (saw_wlast) b_owed++;
                if (!m_axi_bvalid && b_owed > 0 && (!stall_en || $urandom_range(0, 2) == 0)) begin
                    m_axi_bvalid = 1'b1;
                    m_axi_bresp  = (b_idx == err_idx) ? 2'b10 : 2'b00;
                    b_idx++;
                    b_owed--;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_xfer(input logic [AW-1:0] src, input logic [31:0] dest, input logic [15:0] len);
        for (int r = 0; r < int'(len); r++) begin
            logic [AW-1:0] row;
            row = src + AW'(r);
            exp_rows.push_back(row);
            exp_aw.push_back((dest & 32'hFFFF_FFC0) + 32'(r * 64));
            for (int w = 0; w < SAW; w++) exp_w.push_back(mem_word(row, w));
        end
        b_idx = 0;
        @(posedge clk); #1;
        start_pulse = 1'b1; src_addr = src; dest_addr = dest; length = len;
        start_cyc = cyc;
        @(posedge clk); #1;
        start_pulse = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        seen = (done_cnt != d0);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, buf_rd_en, done_irq, busy, error} !== 7'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b expected 0000000",
                {m_axi_awvalid, m_axi_wvalid, m_axi_bready, buf_rd_en, done_irq, busy, error});
        end
        n_cmp++;
        if (m_axi_awaddr !== 32'd0 || m_axi_wdata !== 32'd0 || buf_rd_addr !== '0 || m_axi_awlen !== 8'd0) begin
            n_bad++; $display("FAIL reset_data: awaddr=%h wdata=%h rdaddr=%0d awlen=%0d expected all 0",
                m_axi_awaddr, m_axi_wdata, buf_rd_addr, m_axi_awlen);
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_single_row;
        bit seen;
        stall_en = 1'b0;
        seed = 32'hFFFF_FFB0;   // row 5 then holds words 0..15
        start_xfer(10'd5, 32'h1000, 16'd1);
        wait_done(200, seen);
        n_cmp++;
        if (!seen || done_rel !== 20) begin
            n_bad++; $display("FAIL single_done: seen=%0d cycle=%0d expected cycle 20", seen, done_rel);
        end
        n_cmp++;
        if (rd_rel !== 1 || aw_rel !== 3 || wlast_rel !== 18) begin
            n_bad++; $display("FAIL single_timing: rd=%0d aw=%0d wlast=%0d expected 1/3/18", rd_rel, aw_rel, wlast_rel);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || exp_w.size() != 0 || exp_aw.size() != 0) begin
            n_bad++; $display("FAIL single_end: busy=%b pending_w=%0d pending_aw=%0d expected 0/0/0",
                busy, exp_w.size(), exp_aw.size());
        end
    endtask

    task automatic test_wrap_stalls;
        bit seen;
        int d0;
        stall_en = 1'b1;
        seed = 32'hA5A5_0000;
        d0 = done_cnt;
        start_xfer(10'd1022, 32'h3000, 16'd3);
        wait_done(3000, seen);
        stall_en = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (!seen || done_cnt - d0 !== 1) begin
            n_bad++; $display("FAIL wrap_done: done pulses=%0d expected 1", done_cnt - d0);
        end
        n_cmp++;
        if (exp_rows.size() != 0 || exp_aw.size() != 0 || exp_w.size() != 0 || error !== 1'b0) begin
            n_bad++; $display("FAIL wrap_end: rows=%0d aw=%0d w=%0d error=%b expected 0/0/0/0",
                exp_rows.size(), exp_aw.size(), exp_w.size(), error);
        end
    endtask

    task automatic test_zero_length;
        bit seen;
        int r0 = rd_cnt, a0 = awv_cnt, w0 = wv_cnt;
        start_xfer(10'd9, 32'h4000, 16'd0);
        wait_done(50, seen);
        n_cmp++;
        if (!seen || done_rel !== 1) begin
            n_bad++; $display("FAIL zero_done: seen=%0d cycle=%0d expected cycle 1", seen, done_rel);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (rd_cnt != r0 || awv_cnt != a0 || wv_cnt != w0) begin
            n_bad++; $display("FAIL zero_traffic: rd=%0d awvalid=%0d wvalid=%0d cycles, expected 0",
                rd_cnt - r0, awv_cnt - a0, wv_cnt - w0);
        end
    endtask

    task automatic test_bresp_error;
        bit seen;
        seed = 32'h0BAD_0000;
        err_idx = 1;
        start_xfer(10'd40, 32'h8000, 16'd4);
        wait_done(400, seen);
        @(negedge clk); #1;
        err_idx = -1;
        n_cmp++;
        if (!seen || error !== 1'b1) begin
            n_bad++; $display("FAIL bresp_error: seen=%0d error=%b expected 1", seen, error);
        end
        n_cmp++;
        if (exp_aw.size() != 0 || exp_w.size() != 0) begin
            n_bad++; $display("FAIL bresp_bursts: pending aw=%0d w=%0d expected 0", exp_aw.size(), exp_w.size());
        end
        start_xfer(10'd60, 32'h9000, 16'd1);
        #1;
        n_cmp++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL bresp_clear: error=%b busy=%b expected 0/1", error, busy);
        end
        wait_done(200, seen);
        n_cmp++;
        if (!seen || error !== 1'b0) begin
            n_bad++; $display("FAIL bresp_clean: seen=%0d error=%b expected 1/0", seen, error);
        end
    endtask

    task automatic test_busy_ignore;
        bit seen;
        int d0;
        seed = 32'h1234_0000;
        d0 = done_cnt;
        start_xfer(10'd7, 32'h1007, 16'd1);
        repeat (3) @(posedge clk);
        #1;
        start_pulse = 1'b1; src_addr = 10'd9; dest_addr = 32'h5000; length = 16'd2;
        @(posedge clk); #1;
        start_pulse = 1'b0;
        wait_done(200, seen);
        repeat (60) @(negedge clk);
        n_cmp++;
        if (!seen || done_cnt - d0 !== 1 || done_rel !== 20) begin
            n_bad++; $display("FAIL busy_ignore: done pulses=%0d cycle=%0d expected 1 at 20", done_cnt - d0, done_rel);
        end
        n_cmp++;
        if (exp_rows.size() != 0 || exp_aw.size() != 0 || exp_w.size() != 0) begin
            n_bad++; $display("FAIL busy_queues: rows=%0d aw=%0d w=%0d expected 0", exp_rows.size(), exp_aw.size(), exp_w.size());
        end
    endtask

    task automatic test_reset_mid_burst;
        bit seen;
        int n = 0;
        seed = 32'h7777_0000;
        start_xfer(10'd3, 32'h2000, 16'd2);
        while (!(m_axi_wvalid && w_beat == 7) && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        n_cmp++;
        if (!(m_axi_wvalid && w_beat == 7)) begin
            n_bad++; $display("FAIL midrst_reach: beat 7 not reached, beat=%0d", w_beat);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, buf_rd_en, busy} !== 5'b0 || m_axi_wdata !== 32'd0) begin
            n_bad++; $display("FAIL midrst_drop: ctrl=%b wdata=%h expected 00000 and 0",
                {m_axi_awvalid, m_axi_wvalid, m_axi_bready, buf_rd_en, busy}, m_axi_wdata);
        end
        exp_rows.delete(); exp_aw.delete(); exp_w.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        seed = 32'h3333_0000;
        start_xfer(10'd100, 32'h6040, 16'd1);
        wait_done(200, seen);
        @(negedge clk); #1;
        n_cmp++;
        if (!seen || done_rel !== 20 || exp_w.size() != 0 || exp_aw.size() != 0) begin
            n_bad++; $display("FAIL midrst_recover: seen=%0d cycle=%0d pending w=%0d aw=%0d expected done at 20, none pending",
                seen, done_rel, exp_w.size(), exp_aw.size());
        end
    endtask

    initial begin
        for (int w = 0; w < SAW; w++) buf_rd_data[w] = '0;
        test_reset;
        test_single_row;
        test_wrap_stalls;
        test_zero_length;
        test_bresp_error;
        test_busy_ignore;
        test_reset_mid_burst;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_writeback_dma.md
# axi_writeback_dma

Write-back DMA engine that answers the control unit's AXI-master command interface (start pulse, destination address, source row, length, done interrupt). It reads result rows from the TPU core's output buffer read port and streams them to system memory over an AXI4 write channel. One row of `SYSTOLIC_ARRAY_WIDTH` int32 words becomes one 16-beat INCR burst. It sits between the control unit / TPU core and the SoC interconnect.

## Interface
- `SYSTOLIC_ARRAY_WIDTH`, 16: words per buffer row; equals beats per burst.
- `DATA_WIDTH_ACCUM`, 32: word width; equals AXI data width.
- `ADDR_WIDTH`, 10: buffer row address width.
- `clk`  in  1  single clock, all logic rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start_pulse`  in  1  one-cycle command strobe.
- `dest_addr`  in  32  byte address of the first row in memory.
- `src_addr`  in  ADDR_WIDTH  first buffer row.
- `length`  in  16  number of rows to transfer.
- `done_irq`  out  1  one-cycle completion pulse.
- `busy`  out  1  high from the accepted start until the `done_irq` cycle inclusive.
- `error`  out  1  sticky flag: a non-OKAY BRESP was seen.
- `buf_rd_addr`  out  ADDR_WIDTH  buffer read row.
- `buf_rd_en`  out  1  buffer read strobe.
- `buf_rd_data`  in  DATA_WIDTH_ACCUM × SYSTOLIC_ARRAY_WIDTH (unpacked)  row data, valid one cycle after `buf_rd_en`.
- `m_axi_awaddr` 32, `m_axi_awlen` 8, `m_axi_awsize` 3, `m_axi_awburst` 2, `m_axi_awvalid` 1: outputs.
- `m_axi_awready`  in  1.
- `m_axi_wdata` 32, `m_axi_wstrb` 4, `m_axi_wlast` 1, `m_axi_wvalid` 1: outputs.
- `m_axi_wready`  in  1.
- `m_axi_bresp` 2, `m_axi_bvalid` 1: inputs.
- `m_axi_bready`  out  1.

## Operation
- FSM states: IDLE → RD_REQ → RD_WAIT → BURST → RESP → (RD_REQ | DONE) → IDLE.
- IDLE:
  - `start_pulse` latches `dest_addr` with bits [5:0] masked to 0, latches `src_addr` and `length`, and clears `error`.
  - If `length`==0, go to DONE with no AXI or buffer traffic; otherwise go to RD_REQ.
  - `start_pulse` outside IDLE is ignored.
- RD_REQ: `buf_rd_en`=1 with `buf_rd_addr`=current row, for exactly one cycle.
- RD_WAIT: capture the full `buf_rd_data` row into the serializer.
- BURST: AW and W channels are independent and may complete in either order.
  - `awaddr`=row base, `awlen`=SYSTOLIC_ARRAY_WIDTH-1, `awsize`=3'b010, `awburst`=INCR.
  - W beats go out in order word 0 … word 15; `wstrb`=4'hF; `wlast` is high on beat 15 only.
  - Leave BURST when both the AW handshake and the last W handshake are done.
- RESP: `bready`=1 until the B handshake. BRESP≠OKAY sets `error`; the transfer continues regardless.
- After the B handshake:
  - Row address increments and wraps modulo 2^ADDR_WIDTH.
  - Destination advances by SYSTOLIC_ARRAY_WIDTH×4 bytes (64).
  - Remaining count decrements. If it reaches 0, go to DONE; else go to RD_REQ.
- DONE: `done_irq`=1 for one cycle, then IDLE.
- Valid/ready rules: once asserted, `awvalid` and `wvalid` stay high with stable payload until their handshake. Valid never depends combinationally on ready.
- Only one burst is outstanding at a time.

## Timing
- Reset (asynchronous, immediate): state=IDLE, all valids, `bready`, `buf_rd_en`, `done_irq`, `busy` and `error` go to 0. All address and data outputs go to 0.
- Reset mid-transfer abandons the burst with no further beats. The bench must treat the interconnect as reset too.
- With zero wait states and start accepted in cycle 0:
  - `buf_rd_en` in cycle 1; capture in cycle 2.
  - AW and W beat 0 in cycle 3; `wlast` in cycle 18.
  - `bready` from cycle 19; with `bvalid` in cycle 19, next row's `buf_rd_en` is in cycle 20. That is 19 cycles per row.
  - Final row: `done_irq` in the cycle after the last B handshake.
- `length`=0: `done_irq` in cycle 1.
- W backpressure stalls only the beat pointer. A stall on `awready` does not block W beats.

## Structure
- Package `tpu_dma_pkg`: FSM state enum, AXI constants (BURST_INCR, RESP_OKAY, SIZE_4B), beat-count width `$clog2(SYSTOLIC_ARRAY_WIDTH)`.
- Sub-module `row_serializer`:
  - Parallel load of one row; `valid`/`ready`/`last` beat output; 4-bit beat counter.
  - Instantiated once.
- Top: FSM, address/length counters, AW register, B handling.

## Test plan
- Start with `src`=5, `dest`=0x1000, `length`=1, buffer row 5 = words 0..15 → one AW (0x1000, len 15, INCR, size 2); 16 beats in word order; `wlast` on beat 15; `done_irq` in cycle 20.
- `length`=3, `src`=1022 (ADDR_WIDTH 10), random `wready`/`awready`/`bvalid` stalls → rows read are 1022, 1023, 0; AW addresses are base, +64, +128; data intact; exactly one `done_irq`.
- `length`=0 → `done_irq` in cycle 1; no `buf_rd_en`, `awvalid` or `wvalid`.
- BRESP=SLVERR on row 2 of 4 → all 4 bursts complete; `error`=1 after `done_irq`; next accepted start clears `error`.
- `start_pulse` while busy, and `dest_addr`=0x1007 → second start ignored; AW address is 0x1000.
- Assert `rst` low during beat 7 → all valids drop asynchronously. After release, a new start works normally.
